muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer that borrows the 16-bit ALU for iterative shift-add multiply and restoring divide.
- Sits beside the execute stage.
  - While it owns the ALU (alu_en=1), the datapath muxes the ALU x/y/op/Cin from this block.
  - Results land in MIPS-style HI/LO registers held inside the block.

Parameters:
- WIDTH, 16, operand width; must equal the ALU width.
- CNT_W, 5, iteration counter width; holds values 0..WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_div  in  1  0 = multiply, 1 = divide; sampled with start.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when hi/lo are valid.
- div_zero  out  1  set with done when divisor = 0; cleared at next accepted start.
- hi  out  WIDTH  product[31:16] / remainder.
- lo  out  WIDTH  product[15:0] / quotient.
- alu_en  out  1  block owns ALU this cycle.
- alu_x  out  WIDTH  ALU x operand.
- alu_y  out  WIDTH  ALU y operand.
- alu_op  out  3  ALU op; 000 = add, 100 = sub.
- alu_cin  out  1  ALU carry-in; always 0.
- alu_res  in  WIDTH  ALU result, combinational same cycle.
- alu_cout  in  1  ALU carry-out.
  - add: carry out of bit WIDTH-1.
  - sub: 1 iff x >= y unsigned (no borrow).

Behaviour:
- Reset: state = IDLE; busy, done, div_zero, alu_en = 0; hi, lo, counter = 0; alu_x, alu_y = 0; alu_op = 000.
- Outputs are registered except alu_x/alu_y/alu_op/alu_en, which decode combinationally from state and registers.
- The ALU is a combinational loop partner; its result is consumed in the same cycle.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 → latch b into operand register d; clear div_zero; counter = 0.
  - Multiply: hi = 0, lo = a → MUL.
  - Divide, b ≠ 0: hi = 0, lo = a → DIV.
  - Divide, b = 0: hi = a, lo = all-ones, div_zero = 1 → DONE. No ALU use; done appears the next cycle.
- MUL, one iteration per cycle:
  - alu_x = hi, alu_y = d, alu_op = 000, alu_en = 1.
  - If lo[0] = 1: {hi,lo} ← {alu_cout, alu_res, lo[WIDTH-1:1]}.
  - Else: {hi,lo} ← {1'b0, hi, lo[WIDTH-1:1]}.
  - counter++; after WIDTH iterations → DONE.
- DIV, restoring, one iteration per cycle:
  - Shifted remainder sr = {hi[WIDTH-2:0], lo[WIDTH-1]}; top bit t = hi[WIDTH-1].
  - alu_x = sr, alu_y = d, alu_op = 100, alu_en = 1.
  - If t = 1 or alu_cout = 1: hi ← alu_res, lo ← {lo[WIDTH-2:0], 1}.
  - Else: hi ← sr, lo ← {lo[WIDTH-2:0], 0}.
  - After WIDTH iterations → DONE.
- DONE: done = 1 for exactly one cycle, busy = 0, alu_en = 0 → IDLE.
  - hi/lo/div_zero hold until the next accepted start.
- Latency, start sampled at cycle N:
  - busy = 1 for cycles N+1..N+WIDTH.
  - done = 1 at cycle N+WIDTH+1 (N+17 at default).
  - Divide-by-zero: done at N+2.
- start while not IDLE is ignored (no queuing, no effect on operands). start in the DONE cycle is also ignored.
- rst mid-operation returns to the reset state on the next edge.
  - The partial result is discarded; no done pulse.
- Widths: all arithmetic is unsigned modulo 2^WIDTH per ALU step.
  - Multiply needs one extra carry bit per step (alu_cout).
  - Divide needs the shifted-out top bit t to handle divisor > 2^(WIDTH-1).

Decomposition:
- Shared package (muldiv_pkg), contents:
  - state encoding (IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3);
  - ALU op constants ALU_ADD = 3'b000, ALU_AND = 3'b001, ALU_OR = 3'b010, ALU_SLT = 3'b011, ALU_SUB = 3'b100;
  - WIDTH default.
- One natural sub-module: muldiv_fsm (state register, counter, done/busy generation). The hi/lo shift datapath stays in the top.
- The ALU itself is instantiated outside, at the execute-stage level.

Test Plan:
- Multiply: start, is_div=0, a=3, b=5 at cycle 0 → busy cycles 1–16, alu_en=1; done at cycle 17 with hi=0x0000, lo=0x000F, div_zero=0.
- Multiply: a=0xFFFF, b=0xFFFF → done at 17 with hi=0xFFFE, lo=0x0001 (exercises alu_cout carry every step).
- Divide: a=100, b=7 → lo=14, hi=2 at 17. Then a=0xFFFF, b=0x8001 → lo=1, hi=0x7FFE (exercises top-bit t path).
- Divide by zero: a=0x1234, b=0 → done at cycle 2, div_zero=1, hi=0x1234, lo=0xFFFF, alu_en never high. The next accepted start clears div_zero.
- Start during busy: multiply 3×5 started at 0, second start (a=9, b=9) at cycle 5 → result still 15 at cycle 17, no second done.
- Reset at cycle 8 of a multiply → cycle 9: busy=0, hi=lo=0, state IDLE; no done pulse through cycle 20; a new start at 10 gives correct result at 27.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, ALU opcodes
// and the default operand width.
package muldiv_pkg;

   localparam int WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_AND = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer control: state register, iteration counter and registered busy/done.
module muldiv_fsm
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 5
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start_i,
   input  logic   is_div_i,
   input  logic   b_zero_i,
   output state_e state_o,
   output logic   busy_o,
   output logic   done_o
);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  cnt_q <= '0;
                  if (!is_div_i) begin
                     state_q <= ST_MUL;
                     busy_q  <= 1'b1;
                  end else if (b_zero_i) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DIV;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               // A divide-by-zero enters DONE with done low, so it spends one
               // extra cycle here to raise the pulse a cycle later.
               if (done_q) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end else begin
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign state_o = state_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply / restoring divide that borrows the external
// execute-stage ALU; results are held in HI/LO.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             alu_en,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [2:0]       alu_op,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_cout
);

   state_e           state;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] sr;
   logic             b_zero;

   assign b_zero = (b == '0);
   assign sr     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

   muldiv_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start),
      .is_div_i (is_div),
      .b_zero_i (b_zero),
      .state_o  (state),
      .busy_o   (busy),
      .done_o   (done)
   );

   always_comb begin
      alu_en = 1'b0;
      alu_x  = '0;
      alu_y  = '0;
      alu_op = ALU_ADD;
      case (state)
         ST_MUL: begin
            alu_en = 1'b1;
            alu_x  = hi_q;
            alu_y  = d_q;
         end
         ST_DIV: begin
            alu_en = 1'b1;
            alu_x  = sr;
            alu_y  = d_q;
            alu_op = ALU_SUB;
         end
         default: ;
      endcase
   end

   assign alu_cin = 1'b0;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      d_d  = d_q;
      dz_d = dz_q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               d_d  = b;
               dz_d = 1'b0;
               if (is_div && b_zero) begin
                  hi_d = a;
                  lo_d = '1;
                  dz_d = 1'b1;
               end else begin
                  hi_d = '0;
                  lo_d = a;
               end
            end
         end
         ST_MUL: begin
            // The carry out of the add becomes the new top bit of HI.
            if (lo_q[0]) begin
               hi_d = {alu_cout, alu_res[WIDTH-1:1]};
               lo_d = {alu_res[0], lo_q[WIDTH-1:1]};
            end else begin
               hi_d = {1'b0, hi_q[WIDTH-1:1]};
               lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
            end
         end
         ST_DIV: begin
            // A set top bit means the shifted remainder exceeds any divisor.
            if (hi_q[WIDTH-1] || alu_cout) begin
               hi_d = alu_res;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = sr;
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         d_q  <= '0;
         dz_q <= 1'b0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         d_q  <= d_d;
         dz_q <= dz_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU closing the combinational loop.
module tb_muldiv_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, start, is_div;
   logic [W-1:0] a, b;
   logic         busy, done, div_zero, alu_en, alu_cin, alu_cout;
   logic [W-1:0] hi, lo, alu_x, alu_y, alu_res;
   logic [2:0]   alu_op;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int alu_en_cnt = 0;

   muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .is_div(is_div), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
      .alu_en(alu_en), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
      .alu_cin(alu_cin), .alu_res(alu_res), .alu_cout(alu_cout)
   );

   always #5 clk = ~clk;

   // Execute-stage ALU stand-in
   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      case (alu_op)
         3'b000: {alu_cout, alu_res} = {1'b0, alu_x} + {1'b0, alu_y} + {{W{1'b0}}, alu_cin};
         3'b100: begin
            alu_res  = alu_x - alu_y;
            alu_cout = (alu_x >= alu_y);
         end
         3'b001: alu_res = alu_x & alu_y;
         3'b010: alu_res = alu_x | alu_y;
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (done)   done_cnt++;
      if (alu_en) alu_en_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in cycle 0; returns in cycle 1.
   task automatic launch(input logic dv, input logic [W-1:0] av, input logic [W-1:0] bv);
      start  = 1'b1;
      is_div = dv;
      a      = av;
      b      = bv;
      step();
      start  = 1'b0;
      is_div = 1'b0;
      a      = '0;
      b      = '0;
   endtask

   task automatic run_op(input string tag, input logic dv, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dz, input int lat);
      int d0, e0;
      d0 = done_cnt;
      e0 = alu_en_cnt;
      launch(dv, av, bv);
      check({tag, " busy@1"}, busy, (lat != 2));
      check({tag, " dz@1"}, div_zero, exp_dz);
      for (int k = 1; k < lat; k++) begin
         if (k == lat - 1 && lat > 2) check({tag, " busy@last"}, busy, 1'b1);
         step();
      end
      check({tag, " no early done"}, done_cnt - d0, 0);
      check({tag, " done"}, done, 1'b1);
      check({tag, " busy@done"}, busy, 1'b0);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
      check({tag, " dz"}, div_zero, exp_dz);
      step();
      check({tag, " done pulse"}, done, 1'b0);
      check({tag, " alu_en cycles"}, alu_en_cnt - e0, (lat == 2) ? 0 : W);
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; is_div = 1'b0; a = '0; b = '0;
      step();
      step();
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst dz", div_zero, 1'b0);
      check("rst hi", hi, 16'h0);
      check("rst lo", lo, 16'h0);
      check("rst alu_en", alu_en, 1'b0);
      check("rst alu_x", alu_x, 16'h0);
      check("rst alu_op", alu_op, 3'b000);
      rst = 1'b0;
      step();

      run_op("mul 3x5", 1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 17);
      run_op("mul ffff^2", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
      run_op("div 100/7", 1'b1, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 17);
      run_op("div ffff/8001", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17);
      run_op("div by 0", 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2);
      run_op("mul after dz", 1'b0, 16'd300, 16'd200, 16'h0000, 16'hEA60, 1'b0, 17);

      // Start while busy and start in the DONE cycle are both ignored.
      d0 = done_cnt;
      launch(1'b0, 16'd3, 16'd5);
      for (int k = 1; k < 5; k++) step();
      start = 1'b1; a = 16'd9; b = 16'd9;
      step();
      start = 1'b0; a = '0; b = '0;
      for (int k = 6; k < 17; k++) step();
      check("busy-start done", done, 1'b1);
      check("busy-start lo", lo, 16'h000F);
      check("busy-start hi", hi, 16'h0000);
      start = 1'b1; is_div = 1'b0; a = 16'd9; b = 16'd9;
      step();
      start = 1'b0; a = '0; b = '0;
      check("done-start busy@18", busy, 1'b0);
      step();
      check("done-start busy@19", busy, 1'b0);
      check("done-start lo held", lo, 16'h000F);
      step();
      step();
      check("single done", done_cnt - d0, 1);

      // Reset in cycle 8 aborts the multiply without a done pulse.
      d0 = done_cnt;
      launch(1'b0, 16'd7, 16'd6);
      for (int k = 1; k < 8; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort hi", hi, 16'h0);
      check("abort lo", lo, 16'h0);
      check("abort alu_en", alu_en, 1'b0);
      step();
      check("abort no done", done_cnt - d0, 0);
      run_op("mul after rst", 1'b0, 16'd12, 16'd11, 16'h0000, 16'd132, 1'b0, 17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
